// File: rtl/alu_core.sv
// alu_core: registered integer ALU for the execute stage.
// The operation is computed combinationally from the sampled inputs and
// captured in a single output register together with its status flags.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_ROL   = 4'b1110;
  localparam logic [3:0] OP_ROR   = 4'b1111;

  // Signed overflow of a + b: same operand signs, result sign differs.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of a - b: operand signs differ, result sign differs from a.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [WIDTH-1:0]   sra_v;
  logic        [WIDTH:0]     sum_v;
  logic        [WIDTH:0]     diff_v;
  logic        [SH_W-1:0]    sh;
  logic        [2*WIDTH-1:0] dbl_l;
  logic        [2*WIDTH-1:0] dbl_r;
  logic        [WIDTH-1:0]   alu_res;
  logic                      alu_c;
  logic                      alu_v;

  logic [WIDTH-1:0] result_d,   result_q;
  logic             out_valid_d, out_valid_q;
  logic             zero_d,     zero_q;
  logic             negative_d, negative_q;
  logic             carry_d,    carry_q;
  logic             overflow_d, overflow_q;

  assign a_s = a;
  assign b_s = b;

  // Operation decode: result, carry/borrow and signed overflow for the request.
  always_comb begin
    sum_v   = {1'b0, a} + {1'b0, b};
    diff_v  = {1'b0, a} - {1'b0, b};
    sh      = b[SH_W-1:0];
    sra_v   = a_s >>> sh;
    // Rotates use a doubled copy of a so the wrapped bits fall out of a plain shift.
    dbl_l   = {a, a} << sh;
    dbl_r   = {a, a} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_control)
      OP_NOP:   alu_res = '0;
      OP_ADD: begin
        alu_res = sum_v[WIDTH-1:0];
        alu_c   = sum_v[WIDTH];
        alu_v   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_v[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_v[WIDTH-1:0];
        alu_c   = diff_v[WIDTH];
        alu_v   = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_v[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOR:   alu_res = ~(a | b);
      OP_NOT:   alu_res = ~a;
      OP_SLL:   alu_res = a << sh;
      OP_SRL:   alu_res = a >> sh;
      OP_SRA:   alu_res = sra_v;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASSB: alu_res = b;
      OP_ROL:   alu_res = dbl_l[2*WIDTH-1:WIDTH];
      OP_ROR:   alu_res = dbl_r[WIDTH-1:0];
      default:  alu_res = '0;
    endcase
  end

  // Next state: load on a request, otherwise hold result and flags.
  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      negative_d = alu_res[WIDTH-1];
      carry_d    = alu_c;
      overflow_d = alu_v;
    end
  end

  // Output register; reset clears everything, including the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: table-driven vectors through a scoreboard, plus hand sequences
// for reset and hold behaviour.
module tb_alu_core;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    alu_control = 4'b0000;
  logic [W-1:0]  result;
  logic          out_valid;
  logic          zero;
  logic          negative;
  logic          carry;
  logic          overflow;

  alu_core #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .out_valid   (out_valid),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic [3:0]   flags;   // {zero, negative, carry, overflow}
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] res, input logic [3:0] flags);
    vec_t v;
    v.name = name; v.op = op; v.va = va; v.vb = vb; v.res = res; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = v.op;
    a           = v.va;
    b           = v.vb;
    e.name = v.name; e.res = v.res; e.flags = v.flags;
    sb_q.push_back(e);
  endtask

  // Monitor: out_valid must follow a request by one edge; each valid output pops the scoreboard.
  logic req_s;
  exp_t got_e;
  always @(posedge clk) begin
    req_s = in_valid && rst_n;
    #1;
    if (sb_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, req_s});
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          got_e = sb_q.pop_front();
          chk(got_e.name, {12'd0, result, zero, negative, carry, overflow},
              {12'd0, got_e.res, got_e.flags});
        end
      end
    end
  end

  initial begin
    vec_t hv;
    //            name         op       a        b        result   {z,n,c,v}
    add_vec("add_10_5",   4'b0001, 16'd10,  16'd5,   16'd15,  4'b0000);
    add_vec("sub_10_5",   4'b0010, 16'd10,  16'd5,   16'd5,   4'b0000);
    add_vec("and",        4'b0011, 16'h000A, 16'h000C, 16'h0008, 4'b0000);
    add_vec("or",         4'b0100, 16'h000A, 16'h000C, 16'h000E, 4'b0000);
    add_vec("xor",        4'b0101, 16'h000A, 16'h000C, 16'h0006, 4'b0000);
    add_vec("nor",        4'b0110, 16'h000A, 16'h000C, 16'hFFF1, 4'b0100);
    add_vec("add_ovf",    4'b0001, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    add_vec("add_carry",  4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    add_vec("sub_borrow", 4'b0010, 16'd5,   16'd10,  16'hFFFB, 4'b0110);
    add_vec("sub_ovf",    4'b0010, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    add_vec("sub_zero",   4'b0010, 16'd5,   16'd5,   16'h0000, 4'b1000);
    add_vec("sll",        4'b1000, 16'h8001, 16'd1,  16'h0002, 4'b0000);
    add_vec("srl",        4'b1001, 16'h8001, 16'd1,  16'h4000, 4'b0000);
    add_vec("sra",        4'b1010, 16'h8001, 16'd1,  16'hC000, 4'b0100);
    add_vec("rol",        4'b1110, 16'h8001, 16'd1,  16'h0003, 4'b0000);
    add_vec("ror",        4'b1111, 16'h8001, 16'd1,  16'hC000, 4'b0100);
    add_vec("slt",        4'b1011, 16'h8001, 16'd1,  16'h0001, 4'b0000);
    add_vec("sltu",       4'b1100, 16'h8001, 16'd1,  16'h0000, 4'b1000);
    add_vec("slt_pos",    4'b1011, 16'h0001, 16'h8001, 16'h0000, 4'b1000);
    add_vec("nop",        4'b0000, 16'h1234, 16'h5678, 16'h0000, 4'b1000);
    add_vec("not",        4'b0111, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100);
    add_vec("passb",      4'b1101, 16'h1111, 16'h8000, 16'h8000, 4'b0100);
    add_vec("sll_sh0",    4'b1000, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
    add_vec("rol_4",      4'b1110, 16'h1234, 16'h0004, 16'h2341, 4'b0000);
    add_vec("ror_sh0",    4'b1111, 16'h0001, 16'h0000, 16'h0001, 4'b0000);
    add_vec("sra_15",     4'b1010, 16'h8000, 16'd15, 16'hFFFF, 4'b0100);
    add_vec("srl_15",     4'b1001, 16'h8000, 16'd15, 16'h0001, 4'b0000);

    // Reset state.
    #12;
    chk("reset_state", {26'd0, result[W-1:0] == '0 ? 1'b0 : 1'b1, zero, negative, carry, overflow, out_valid}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b1;

    // Back-to-back table vectors.
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    chk("table_drain", sb_q.size(), 32'd0);

    // Hold: idle cycles with changing operands keep the last result.
    hv.name = "hold_add"; hv.op = 4'b0001; hv.va = 16'd10; hv.vb = 16'd5;
    hv.res = 16'd15; hv.flags = 4'b0000;
    drive(hv);
    @(negedge clk);
    in_valid = 1'b0; alu_control = 4'b0010; a = 16'hFFFF; b = 16'h1234;
    @(posedge clk); #1;
    chk("hold_1", {15'd0, result, out_valid}, {15'd0, 16'd15, 1'b0});
    @(negedge clk);
    alu_control = 4'b1101; a = 16'h0000; b = 16'hABCD;
    @(posedge clk); #1;
    chk("hold_2", {12'd0, result, zero, negative, carry, overflow}, {12'd0, 16'd15, 4'b0000});
    @(negedge clk);

    // Asynchronous reset while a request is in flight.
    sb_en = 1'b0;
    in_valid = 1'b1; alu_control = 4'b0001; a = 16'd3; b = 16'd4;
    @(posedge clk); #2;
    chk("rst_pre", {15'd0, result, out_valid}, {15'd0, 16'd7, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {11'd0, result, zero, negative, carry, overflow, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rst_held", {11'd0, result, zero, negative, carry, overflow, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", {11'd0, result, zero, negative, carry, overflow, out_valid}, 32'd0);
    @(negedge clk);
    sb_en = 1'b1;

    // One more request after reset to confirm normal operation resumes.
    hv.name = "post_rst_xor"; hv.op = 4'b0101; hv.va = 16'hFFFF; hv.vb = 16'hFFFF;
    hv.res = 16'h0000; hv.flags = 4'b1000;
    drive(hv);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    chk("final_drain", sb_q.size(), 32'd0);
    @(negedge clk);
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name:
alu_core

Overview:
- Registered 16-bit integer ALU for the datapath execute stage.
- Takes two operands and a 4-bit operation code, and produces a result plus status flags one clock after a valid request.
- Purely single-issue: no internal pipeline beyond the output register, no stall or back-pressure.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a power of two, at least 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request strobe; operands and opcode are sampled when high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, the low log2(WIDTH) bits are the shift amount
- alu_control  input  4  operation select
- result  output  WIDTH  registered result
- out_valid  output  1  high for one cycle when result and flags are updated
- zero  output  1  result equals 0
- negative  output  1  result MSB
- carry  output  1  add: carry-out; sub: borrow (1 when a < b unsigned); otherwise 0
- overflow  output  1  signed overflow for add/sub; otherwise 0

Behaviour:
- Reset: rst_n low asynchronously clears result, zero, negative, carry, overflow and out_valid to 0.
  - Reset asserted mid-operation discards the pending request; out_valid is not raised for it.
- Latency: exactly 1 cycle.
  - in_valid high at edge N loads result and flags at edge N.
  - out_valid is high during cycle N+1.
  - Back-to-back requests every cycle are supported.
- in_valid low at an edge: result and flags hold their previous values; out_valid goes 0.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0000 NOP: result 0, flags computed from 0 (zero=1)
  - 0001 ADD: a + b
  - 0010 SUB: a - b
  - 0011 AND: a & b
  - 0100 OR: a | b
  - 0101 XOR: a ^ b
  - 0110 NOR: ~(a | b)
  - 0111 NOT: ~a
  - 1000 SLL: a << b[sh]
  - 1001 SRL: logical right shift of a by b[sh]
  - 1010 SRA: arithmetic right shift of a by b[sh]
  - 1011 SLT: 1 if a < b signed, else 0
  - 1100 SLTU: 1 if a < b unsigned, else 0
  - 1101 PASSB: b
  - 1110 ROL: rotate a left by b[sh]
  - 1111 ROR: rotate a right by b[sh]
  - Here sh = log2(WIDTH) bits; shift amount 0 returns a unchanged.
- Flags:
  - zero and negative are derived from the registered result for every opcode.
  - ADD carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - ADD overflow = operands have the same sign and the result sign differs.
  - SUB carry = borrow.
  - SUB overflow = operands have different signs and the result sign differs from a.
  - All other opcodes: carry = 0, overflow = 0.
- Datapath is combinational from the sampled inputs to the D inputs of the output register. There are no X outputs for any opcode.
- Operands changing while in_valid is low have no effect on the outputs.

Test Plan:
- Reset: assert rst_n=0 mid-run with in_valid=1 -> result=0, all flags 0, out_valid=0 immediately; after release with no request, outputs stay 0.
- Basic ops, one per cycle, a=10, b=5:
  - ADD -> 15, carry=0, overflow=0
  - SUB -> 5, carry=0
  - out_valid is high the cycle after each request.
- Logic, a=0x000A, b=0x000C:
  - AND -> 0x0008
  - OR -> 0x000E
  - XOR -> 0x0006
  - NOR -> 0xFFF1, negative=1
- Arithmetic boundaries:
  - ADD 0x7FFF+0x0001 -> 0x8000, overflow=1, negative=1, carry=0
  - ADD 0xFFFF+0x0001 -> 0x0000, zero=1, carry=1
  - SUB 5-10 -> 0xFFFB, carry=1, negative=1
- Shifts and compares, a=0x8001:
  - SLL b=1 -> 0x0002
  - SRL b=1 -> 0x4000
  - SRA b=1 -> 0xC000
  - ROL b=1 -> 0x0003
  - SLT a=0x8001, b=1 -> 1
  - SLTU with the same operands -> 0
- Hold behaviour: after an ADD producing 15, drive in_valid=0 with new operands -> result stays 15, out_valid=0.
